circle_plotter: RTL and testbench

Parametrised Bresenham circle/arc rasteriser that drives the VGA adapter pixel port. It optionally clears the screen first, then plots a circle of given centre, radius and colour, with per-octant masking so arcs can be drawn for later Reuleaux-style composites. It sits between the lab top level (switch/key decode) and the VGA adapter, and generalises the fixed 160x120 shape drawers to arbitrary screen size and radius width.

---
 rtl/lab_pkg.sv | 22 ++
 rtl/circle_octant_gen.sv | 49 ++++
 rtl/circle_plotter.sv | 223 ++++++++++++++++++++++
 tb/tb_circle_plotter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab_pkg.sv
// Shared types and screen constants for the lab shape drawers.
package lab_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    INIT,
    PLOT,
    DONE
  } circle_state_t;

  localparam int DEFAULT_SCREEN_W = 160;
  localparam int DEFAULT_SCREEN_H = 120;
  localparam logic [2:0] BLACK = 3'b000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/circle_octant_gen.sv
// Maps an octant slot and Bresenham offsets to a screen pixel plus a bounds flag.
module circle_octant_gen
  import lab_pkg::*;
#(
  parameter int SCREEN_W = DEFAULT_SCREEN_W,
  parameter int SCREEN_H = DEFAULT_SCREEN_H,
  parameter int X_W      = $clog2(SCREEN_W),
  parameter int Y_W      = $clog2(SCREEN_H),
  parameter int AW       = 10
) (
  input  logic [2:0]           slot,
  input  logic [X_W-1:0]       cx,
  input  logic [Y_W-1:0]       cy,
  input  logic signed [AW-1:0] ox,
  input  logic signed [AW-1:0] oy,
  output logic [X_W-1:0]       x,
  output logic [Y_W-1:0]       y,
  output logic                 in_bounds
);

  localparam logic signed [AW-1:0] W_LIM = AW'(SCREEN_W);
  localparam logic signed [AW-1:0] H_LIM = AW'(SCREEN_H);

  logic signed [AW-1:0] cx_s;
  logic signed [AW-1:0] cy_s;
  logic signed [AW-1:0] sx;
  logic signed [AW-1:0] sy;

  always_comb begin
    cx_s = $signed({{(AW-X_W){1'b0}}, cx});
    cy_s = $signed({{(AW-Y_W){1'b0}}, cy});
    sx   = '0;
    sy   = '0;
    case (slot)
      3'd0: begin sx = cx_s + ox; sy = cy_s + oy; end
      3'd1: begin sx = cx_s + oy; sy = cy_s + ox; end
      3'd2: begin sx = cx_s - ox; sy = cy_s + oy; end
      3'd3: begin sx = cx_s - oy; sy = cy_s + ox; end
      3'd4: begin sx = cx_s - ox; sy = cy_s - oy; end
      3'd5: begin sx = cx_s - oy; sy = cy_s - ox; end
      3'd6: begin sx = cx_s + ox; sy = cy_s - oy; end
      default: begin sx = cx_s + oy; sy = cy_s - ox; end
    endcase
    in_bounds = !sx[AW-1] && (sx < W_LIM) && !sy[AW-1] && (sy < H_LIM);
    x = sx[X_W-1:0];
    y = sy[Y_W-1:0];
  end

endmodule

// File: rtl/circle_plotter.sv
// Bresenham circle/arc rasteriser with optional screen clear, driving the VGA pixel port.
module circle_plotter
  import lab_pkg::*;
#(
  parameter int SCREEN_W = DEFAULT_SCREEN_W,
  parameter int SCREEN_H = DEFAULT_SCREEN_H,
  parameter int R_W      = 8,
  parameter int X_W      = $clog2(SCREEN_W),
  parameter int Y_W      = $clog2(SCREEN_H)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           skip_clear,
  input  logic [7:0]     octant_mask,
  input  logic [2:0]     colour,
  input  logic [X_W-1:0] centre_x,
  input  logic [Y_W-1:0] centre_y,
  input  logic [R_W-1:0] radius,
  output logic           done,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_plot
);

  localparam int AW = max3(X_W, Y_W, R_W) + 2;
  localparam logic [X_W-1:0]       X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0]       Y_LAST = Y_W'(SCREEN_H - 1);
  localparam logic signed [AW-1:0] ONE    = AW'(1);

  circle_state_t        state_q, state_d;
  logic [7:0]           mask_q, mask_d;
  logic [2:0]           colour_q, colour_d;
  logic [X_W-1:0]       cx_q, cx_d;
  logic [Y_W-1:0]       cy_q, cy_d;
  logic [R_W-1:0]       radius_q, radius_d;
  logic [X_W-1:0]       clr_x_q, clr_x_d;
  logic [Y_W-1:0]       clr_y_q, clr_y_d;
  logic signed [AW-1:0] ox_q, ox_d;
  logic signed [AW-1:0] oy_q, oy_d;
  logic signed [AW-1:0] crit_q, crit_d;
  logic [2:0]           slot_q, slot_d;
  logic                 done_q, done_d;
  logic [X_W-1:0]       vga_x_q, vga_x_d;
  logic [Y_W-1:0]       vga_y_q, vga_y_d;
  logic [2:0]           vga_colour_q, vga_colour_d;
  logic                 vga_plot_q, vga_plot_d;

  logic signed [AW-1:0] oy_inc;
  logic signed [AW-1:0] ox_dec;
  logic [X_W-1:0]       gen_x;
  logic [Y_W-1:0]       gen_y;
  logic                 gen_in;

  // The generator looks at next-cycle slot/offsets so the pixel lands in the output register on time.
  circle_octant_gen #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .X_W      (X_W),
    .Y_W      (Y_W),
    .AW       (AW)
  ) u_octant_gen (
    .slot      (slot_d),
    .cx        (cx_q),
    .cy        (cy_q),
    .ox        (ox_d),
    .oy        (oy_d),
    .x         (gen_x),
    .y         (gen_y),
    .in_bounds (gen_in)
  );

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    colour_d = colour_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    radius_d = radius_q;
    clr_x_d  = clr_x_q;
    clr_y_d  = clr_y_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    crit_d   = crit_q;
    slot_d   = slot_q;
    done_d   = done_q;
    oy_inc   = oy_q + ONE;
    ox_dec   = ox_q - ONE;

    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          mask_d   = octant_mask;
          colour_d = colour;
          cx_d     = centre_x;
          cy_d     = centre_y;
          radius_d = radius;
          clr_x_d  = '0;
          clr_y_d  = '0;
          state_d  = skip_clear ? INIT : CLEAR;
        end
      end

      CLEAR: begin
        if (clr_y_q == Y_LAST) begin
          clr_y_d = '0;
          if (clr_x_q == X_LAST) begin
            state_d = INIT;
          end else begin
            clr_x_d = clr_x_q + 1'b1;
          end
        end else begin
          clr_y_d = clr_y_q + 1'b1;
        end
      end

      INIT: begin
        ox_d    = $signed({{(AW-R_W){1'b0}}, radius_q});
        oy_d    = '0;
        crit_d  = ONE - ox_d;
        slot_d  = '0;
        state_d = PLOT;
      end

      PLOT: begin
        if (slot_q != 3'd7) begin
          slot_d = slot_q + 3'd1;
        end else begin
          slot_d = '0;
          oy_d   = oy_inc;
          if (crit_q[AW-1] || (crit_q == '0)) begin
            crit_d = crit_q + (oy_inc <<< 1) + ONE;
          end else begin
            ox_d   = ox_dec;
            crit_d = crit_q + ((oy_inc - ox_dec) <<< 1) + ONE;
          end
          if (oy_inc > ox_d) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      DONE: begin
        if (!start) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = BLACK;
    vga_plot_d   = 1'b0;
    if (state_d == CLEAR) begin
      vga_x_d    = clr_x_d;
      vga_y_d    = clr_y_d;
      vga_plot_d = 1'b1;
    end else if (state_d == PLOT) begin
      vga_x_d      = gen_x;
      vga_y_d      = gen_y;
      vga_colour_d = colour_q;
      vga_plot_d   = mask_q[slot_d] && gen_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      colour_q     <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      radius_q     <= '0;
      clr_x_q      <= '0;
      clr_y_q      <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
      crit_q       <= '0;
      slot_q       <= '0;
      done_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      colour_q     <= colour_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      radius_q     <= radius_d;
      clr_x_q      <= clr_x_d;
      clr_y_q      <= clr_y_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      crit_q       <= crit_d;
      slot_q       <= slot_d;
      done_q       <= done_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  assign done       = done_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_circle_plotter.sv
// Directed self-checking bench for circle_plotter at the default 160x120 screen.
module tb_circle_plotter;

  localparam int W = 160;
  localparam int H = 120;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       skip_clear;
  logic [7:0] octant_mask;
  logic [2:0] colour;
  logic [7:0] centre_x;
  logic [6:0] centre_y;
  logic [7:0] radius;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
  } rec_t;

  rec_t obs[$];
  int   exp_x[$];
  int   exp_y[$];
  int   model_iters;
  int   run_cycles;
  int   ref_cycles;
  int   bad;

  always #5 clk = ~clk;

  circle_plotter #(
    .SCREEN_W (W),
    .SCREEN_H (H),
    .R_W      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .skip_clear  (skip_clear),
    .octant_mask (octant_mask),
    .colour      (colour),
    .centre_x    (centre_x),
    .centre_y    (centre_y),
    .radius      (radius),
    .done        (done),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raises start and records every plotted pixel until done or the cycle budget runs out.
  task automatic run_job(input int cx, input int cy, input int r, input logic [7:0] m,
                         input logic sk, input logic [2:0] col, input int limit);
    bit timed_out;
    obs.delete();
    run_cycles  = 0;
    timed_out   = 1'b0;
    centre_x    = 8'(cx);
    centre_y    = 7'(cy);
    radius      = 8'(r);
    octant_mask = m;
    skip_clear  = sk;
    colour      = col;
    start       = 1'b1;
    forever begin
      tick();
      run_cycles++;
      if (vga_plot === 1'b1) obs.push_back('{32'(run_cycles), vga_x, vga_y, vga_colour});
      if (done === 1'b1) break;
      if (run_cycles >= limit) begin
        timed_out = 1'b1;
        break;
      end
    end
    check("job_timeout", 32'(timed_out), 32'd0);
  endtask

  task automatic finish_job();
    start = 1'b0;
    tick();
    check("done_fall", 32'(done), 32'd0);
  endtask

  task automatic model(input int cx, input int cy, input int r, input logic [7:0] m);
    int ox, oy, crit, px, py;
    ox = r;
    oy = 0;
    crit = 1 - r;
    px = 0;
    py = 0;
    exp_x.delete();
    exp_y.delete();
    model_iters = 0;
    while (oy <= ox) begin
      for (int k = 0; k < 8; k++) begin
        case (k)
          0: begin px = cx + ox; py = cy + oy; end
          1: begin px = cx + oy; py = cy + ox; end
          2: begin px = cx - ox; py = cy + oy; end
          3: begin px = cx - oy; py = cy + ox; end
          4: begin px = cx - ox; py = cy - oy; end
          5: begin px = cx - oy; py = cy - ox; end
          6: begin px = cx + ox; py = cy - oy; end
          default: begin px = cx + oy; py = cy - ox; end
        endcase
        if (m[k] && px >= 0 && px < W && py >= 0 && py < H) begin
          exp_x.push_back(px);
          exp_y.push_back(py);
        end
      end
      model_iters++;
      oy++;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin
        ox--;
        crit += 2 * (oy - ox) + 1;
      end
    end
  endtask

  task automatic compare_plots(input string tag, input int first);
    int n;
    int errs;
    n = obs.size() - first;
    errs = 0;
    check({tag, "_count"}, 32'(n), 32'(exp_x.size()));
    if (n > exp_x.size()) n = exp_x.size();
    for (int i = 0; i < n; i++) begin
      if (int'(obs[first+i].x) != exp_x[i] || int'(obs[first+i].y) != exp_y[i]) errs++;
    end
    check({tag, "_pixels"}, 32'(errs), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; skip_clear = 1'b0; octant_mask = '0;
    colour = '0; centre_x = '0; centre_y = '0; radius = '0;
    tick();
    tick();
    check("rst_done", 32'(done), 32'd0);
    check("rst_plot", 32'(vga_plot), 32'd0);
    check("rst_x", 32'(vga_x), 32'd0);
    check("rst_y", 32'(vga_y), 32'd0);
    check("rst_colour", 32'(vga_colour), 32'd0);
    rst = 1'b0;

    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (vga_plot !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    // radius 0: INIT at +1, slots +2..+9, done at +10
    run_job(80, 60, 0, 8'hFF, 1'b1, 3'd5, 50);
    check("r0_done_cycle", 32'(run_cycles), 32'd10);
    check("r0_plots", 32'(obs.size()), 32'd8);
    bad = 0;
    foreach (obs[i]) if (obs[i].x != 8'd80 || obs[i].y != 7'd60 || obs[i].c != 3'd5) bad++;
    check("r0_pixel_vals", 32'(bad), 32'd0);
    if (obs.size() == 8) begin
      check("r0_first_slot", obs[0].cyc, 32'd2);
      check("r0_last_slot", obs[7].cyc, 32'd9);
    end
    finish_job();

    model(80, 60, 40, 8'h01);
    run_job(80, 60, 40, 8'h01, 1'b1, 3'd3, 2000);
    check("m01_cycles", 32'(run_cycles), 32'(2 + 8 * model_iters));
    compare_plots("m01", 0);
    bad = 0;
    foreach (obs[i]) begin
      if (obs[i].x < 8'd80 || obs[i].y < 7'd60 ||
          (int'(obs[i].x) - 80) < (int'(obs[i].y) - 60) || obs[i].c != 3'd3) bad++;
    end
    check("m01_octant0", 32'(bad), 32'd0);
    finish_job();

    run_job(80, 60, 10, 8'hFF, 1'b1, 3'd1, 500);
    ref_cycles = run_cycles;
    finish_job();
    model(0, 0, 10, 8'hFF);
    run_job(0, 0, 10, 8'hFF, 1'b1, 3'd1, 500);
    check("corner_cycles_same", 32'(run_cycles), 32'(ref_cycles));
    check("corner_cycles", 32'(run_cycles), 32'(2 + 8 * model_iters));
    compare_plots("corner", 0);
    bad = 0;
    foreach (obs[i]) if (obs[i].x >= 8'd160 || obs[i].y >= 7'd120) bad++;
    check("corner_bounds", 32'(bad), 32'd0);
    finish_job();

    model(80, 60, 5, 8'hFF);
    run_job(80, 60, 5, 8'hFF, 1'b0, 3'd2, W * H + 200);
    check("clr_cycles", 32'(run_cycles), 32'(W * H + 2 + 8 * model_iters));
    check("clr_enough_plots", 32'(obs.size() >= W * H), 32'd1);
    if (obs.size() >= W * H) begin
      bad = 0;
      for (int i = 0; i < W * H; i++) begin
        if (int'(obs[i].cyc) != i + 1 || int'(obs[i].x) != i / H ||
            int'(obs[i].y) != i % H || obs[i].c != 3'd0) bad++;
      end
      check("clr_raster", 32'(bad), 32'd0);
      compare_plots("clr_circle", W * H);
    end
    finish_job();

    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd5; octant_mask = 8'hFF;
    skip_clear = 1'b0; colour = 3'd7; start = 1'b1;
    repeat (100) tick();
    check("midclr_plot", 32'(vga_plot), 32'd1);
    rst = 1'b1;
    start = 1'b0;
    tick();
    check("midclr_rst_plot", 32'(vga_plot), 32'd0);
    check("midclr_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_idle", 32'(vga_plot), 32'd0);
    run_job(80, 60, 0, 8'hFF, 1'b1, 3'd4, 50);
    check("post_rst_cycles", 32'(run_cycles), 32'd10);
    check("post_rst_plots", 32'(obs.size()), 32'd8);

    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done !== 1'b1) bad++;
    end
    check("done_held", 32'(bad), 32'd0);
    finish_job();

    run_job(30, 40, 0, 8'h01, 1'b1, 3'd6, 50);
    check("second_cycles", 32'(run_cycles), 32'd10);
    check("second_plots", 32'(obs.size()), 32'd1);
    if (obs.size() == 1) begin
      check("second_x", 32'(obs[0].x), 32'd30);
      check("second_y", 32'(obs[0].y), 32'd40);
      check("second_colour", 32'(obs[0].c), 32'd6);
      check("second_slot0", obs[0].cyc, 32'd2);
    end
    finish_job();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
